// File: rtl/mem_bus_arbiter.sv
// Shares one single-port, variable-latency memory bus between instruction fetch and the
// MEM-stage load/store path: data-over-fetch priority, req/ack handshake, result buffering.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stallreq_o,
    input  logic              flush_i,
    input  logic              pipe_stall_i,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, SRV_MEM, SRV_IF} state_e;

    state_e state_q, state_d;

    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              if_buf_valid_q, if_buf_valid_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic              discard_q, discard_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              mem_pend;
    logic              if_pend;
    logic              serving;
    logic              timeout_hit;
    logic              done;
    logic [DATA_W-1:0] rdata_eff;

    assign mem_pend    = mem_ce_i & ~mem_done_q;
    assign if_pend     = if_ce_i & ~if_buf_valid_q & ~flush_i;
    assign serving     = (state_q != IDLE);
    // A timed-out access completes exactly like an ack, but with zero data.
    assign timeout_hit = serving & ~bus_ack_i & (cnt_q == 8'(TIMEOUT - 1));
    assign done        = serving & (bus_ack_i | timeout_hit);
    assign rdata_eff   = bus_ack_i ? bus_rdata_i : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_pend) begin
                    state_d = SRV_MEM;
                end else if (if_pend) begin
                    state_d = SRV_IF;
                end
            end
            SRV_MEM, SRV_IF: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_sel_d      = bus_sel_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        if_data_d      = if_data_q;
        if_buf_valid_d = if_buf_valid_q;
        mem_rdata_d    = mem_rdata_q;
        mem_done_d     = 1'b0;
        discard_d      = discard_q;
        cnt_d          = cnt_q;
        err_d          = err_q;

        if (if_buf_valid_q & (~pipe_stall_i | flush_i)) begin
            if_buf_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                discard_d = 1'b0;
                if (mem_pend) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_sel_d   = mem_sel_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (if_pend) begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = '1;
                    bus_addr_d = if_addr_i;
                end
            end
            SRV_MEM: begin
                cnt_d = cnt_q + 8'd1;
                if (done) begin
                    bus_req_d = 1'b0;
                    err_d     = err_q | timeout_hit;
                    // A request withdrawn mid-access still finishes on the bus; its result is dropped.
                    mem_done_d = mem_ce_i;
                    if (mem_ce_i) begin
                        mem_rdata_d = bus_we_q ? '0 : rdata_eff;
                    end
                end
            end
            SRV_IF: begin
                cnt_d = cnt_q + 8'd1;
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (done) begin
                    bus_req_d = 1'b0;
                    err_d     = err_q | timeout_hit;
                    if (~discard_q & ~flush_i) begin
                        if_buf_valid_d = 1'b1;
                        if_data_d      = rdata_eff;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_sel_q      <= '0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            if_data_q      <= '0;
            if_buf_valid_q <= 1'b0;
            mem_rdata_q    <= '0;
            mem_done_q     <= 1'b0;
            discard_q      <= 1'b0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
        end else begin
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_sel_q      <= bus_sel_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            if_data_q      <= if_data_d;
            if_buf_valid_q <= if_buf_valid_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_done_q     <= mem_done_d;
            discard_q      <= discard_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
        end
    end

    assign if_data_o      = if_data_q;
    assign if_stallreq_o  = if_ce_i & ~if_buf_valid_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign mem_stallreq_o = mem_ce_i & ~mem_done_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized single-requester
// traffic against a behavioural bus slave, a shadow memory and latency arithmetic.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        flush_i = 1'b0;
    logic        pipe_stall_i = 1'b1;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        err_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_stallreq_o(if_stallreq_o), .flush_i(flush_i), .pipe_stall_i(pipe_stall_i),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_stallreq_o(mem_stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] slv_mem [256];
    logic [31:0] ref_mem [256];
    int          slv_lat = 1;
    int          slv_cnt = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [31:0] log_addr [$];
    logic        log_we [$];
    logic [3:0]  log_sel [$];
    logic [31:0] log_wdata [$];
    logic        err_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural bus slave: acks on the slv_lat-th cycle of a request (0 = never acks).
    always @(negedge clk) begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
        if (rst && bus_req_o) begin
            slv_cnt++;
            if (slv_cnt == 1) begin
                cap_addr = bus_addr_o; cap_we = bus_we_o;
                cap_sel  = bus_sel_o;  cap_wdata = bus_wdata_o;
            end else begin
                chk("hold_addr", bus_addr_o, cap_addr);
                chk("hold_we", 32'(bus_we_o), 32'(cap_we));
                chk("hold_sel", 32'(bus_sel_o), 32'(cap_sel));
                chk("hold_wdata", bus_wdata_o, cap_wdata);
            end
            if (slv_lat != 0 && slv_cnt == slv_lat) begin
                bus_ack_i = 1'b1;
                if (bus_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (bus_sel_o[b]) slv_mem[bus_addr_o[9:2]][8*b +: 8] = bus_wdata_o[8*b +: 8];
                end else begin
                    bus_rdata_i = slv_mem[bus_addr_o[9:2]];
                end
                log_addr.push_back(bus_addr_o);
                log_we.push_back(bus_we_o);
                log_sel.push_back(bus_sel_o);
                log_wdata.push_back(bus_wdata_o);
                slv_cnt = 0;
            end
        end else begin
            slv_cnt = 0;
        end
    end

    task automatic mem_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wd, input int lat);
        int n, nreq, exp_n, exp_req, logn;
        logic [31:0] exp_rd;
        logn    = log_addr.size();
        slv_lat = lat;
        exp_n   = (lat == 0) ? int'(TO) + 1 : lat + 1;
        exp_req = (lat == 0) ? int'(TO) : lat;
        exp_rd  = (we || lat == 0) ? 32'h0 : ref_mem[addr[9:2]];
        mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_wdata_i = wd;
        #1;
        n = 0; nreq = 0;
        while (mem_stallreq_o === 1'b1 && n < int'(TO) + 20) begin
            n++;
            tick();
            if (bus_req_o === 1'b1) nreq++;
            if (n == 1) begin
                chk("m_req", 32'(bus_req_o), 32'd1);
                chk("m_addr", bus_addr_o, addr);
                chk("m_we", 32'(bus_we_o), 32'(we));
                chk("m_sel", 32'(bus_sel_o), 32'(sel));
                if (we) chk("m_wdata", bus_wdata_o, wd);
            end
        end
        chk("m_stall_cycles", 32'(n), 32'(exp_n));
        chk("m_req_cycles", 32'(nreq), 32'(exp_req));
        chk("m_rdata", mem_rdata_o, exp_rd);
        chk("m_req_off", 32'(bus_req_o), 32'd0);
        if (lat == 0) err_exp = 1'b1;
        chk("m_err", 32'(err_o), 32'(err_exp));
        if (lat != 0) begin
            chk("m_log_n", 32'(log_addr.size()), 32'(logn + 1));
            if (log_addr.size() == logn + 1) begin
                chk("m_log_addr", log_addr[logn], addr);
                chk("m_log_we", 32'(log_we[logn]), 32'(we));
                chk("m_log_sel", 32'(log_sel[logn]), 32'(sel));
            end
            if (we) ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wd, sel);
        end
        mem_ce_i = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [31:0] addr, input int lat);
        int n;
        logic [31:0] exp_d;
        exp_d   = ref_mem[addr[9:2]];
        slv_lat = lat;
        if_addr_i = addr; if_ce_i = 1'b1; pipe_stall_i = 1'b1;
        #1;
        n = 0;
        while (if_stallreq_o === 1'b1 && n < 50) begin
            n++;
            tick();
            if (n == 1) begin
                chk("f_req", 32'(bus_req_o), 32'd1);
                chk("f_addr", bus_addr_o, addr);
                chk("f_we", 32'(bus_we_o), 32'd0);
                chk("f_sel", 32'(bus_sel_o), 32'hF);
            end
        end
        chk("f_stall_cycles", 32'(n), 32'(lat + 1));
        chk("f_data", if_data_o, exp_d);
        tick();
        chk("f_hold_stall", 32'(if_stallreq_o), 32'd0);
        chk("f_hold_data", if_data_o, exp_d);
        pipe_stall_i = 1'b0;
        tick();
        chk("f_consumed", 32'(if_stallreq_o), 32'd1);
        if_ce_i = 1'b0; pipe_stall_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        logic saw_old;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        slv_mem[0]  = 32'h0000_0013; ref_mem[0]  = 32'h0000_0013;
        slv_mem[16] = 32'hAAAA_0040; ref_mem[16] = 32'hAAAA_0040;
        slv_mem[32] = 32'h5555_0080; ref_mem[32] = 32'h5555_0080;

        // Reset state
        tick(); tick();
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        chk("rst_ifdata", if_data_o, 32'd0);
        chk("rst_mrdata", mem_rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_stalls", 32'({if_stallreq_o, mem_stallreq_o}), 32'd0);
        #2 rst = 1'b1;
        tick();

        // Lone fetch, minimum latency
        fetch(32'h0, 1);

        // Collision: data wins, fetch follows
        slv_lat = 3;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h100;
        if_ce_i = 1'b1; if_addr_i = 32'h0C; pipe_stall_i = 1'b1;
        #1;
        m = 0;
        while (if_stallreq_o === 1'b1 && m < 100) begin
            m++;
            tick();
            if (m == 1) begin
                chk("c_addr_first", bus_addr_o, 32'h100);
                chk("c_we_first", 32'(bus_we_o), 32'd0);
            end
            if (m == 4) begin
                chk("c_mem_done", 32'(mem_stallreq_o), 32'd0);
                chk("c_mem_rdata", mem_rdata_o, ref_mem[64]);
            end
            if (m == 5) begin
                chk("c_done_pulse", 32'(mem_stallreq_o), 32'd1);
                chk("c_addr_second", bus_addr_o, 32'h0C);
                mem_ce_i = 1'b0;
            end
        end
        chk("c_if_stall_cycles", 32'(m), 32'd8);
        chk("c_if_data", if_data_o, ref_mem[3]);
        pipe_stall_i = 1'b0; if_ce_i = 1'b0;
        tick();
        pipe_stall_i = 1'b1;

        // Store then load back the merged word
        mem_access(1'b1, 4'b0011, 32'h204, 32'hDEADBEEF, 3);
        mem_access(1'b0, 4'hF, 32'h204, 32'h0, 2);

        // Flush while fetch in flight
        slv_lat = 4;
        if_addr_i = 32'h40; if_ce_i = 1'b1; pipe_stall_i = 1'b1;
        tick();
        chk("fl_addr0", bus_addr_o, 32'h40);
        tick();
        flush_i = 1'b1; if_addr_i = 32'h80;
        tick();
        flush_i = 1'b0;
        n = 0; saw_old = 1'b0;
        while (if_stallreq_o === 1'b1 && n < 50) begin
            n++;
            tick();
            if (if_data_o === 32'hAAAA_0040) saw_old = 1'b1;
        end
        chk("fl_no_stale", 32'(saw_old), 32'd0);
        chk("fl_stall_cycles", 32'(n), 32'd7);
        chk("fl_data", if_data_o, 32'h5555_0080);
        chk("fl_log_a", log_addr[log_addr.size()-2], 32'h40);
        chk("fl_log_b", log_addr[log_addr.size()-1], 32'h80);

        // Flush while idle with a valid buffer
        flush_i = 1'b1;
        tick();
        chk("fl_idle_clear", 32'(if_stallreq_o), 32'd1);
        flush_i = 1'b0; if_ce_i = 1'b0;
        tick();

        // Randomized single-requester traffic
        for (int i = 0; i < 24; i++) begin
            int kind, lat;
            kind = $urandom_range(0, 2);
            lat  = $urandom_range(1, 5);
            if (kind == 2) fetch(32'(4 * $urandom_range(0, 63)), lat);
            else mem_access(kind == 1, 4'($urandom_range(1, 15)),
                            32'h200 + 32'(4 * $urandom_range(0, 63)), $urandom, lat);
        end

        // Timeout with no ack, then err stays sticky
        mem_access(1'b0, 4'hF, 32'h208, 32'h0, 0);
        mem_access(1'b0, 4'hF, 32'h208, 32'h0, 2);

        // Asynchronous reset in the middle of a data access
        slv_lat = 0;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h20C;
        tick(); tick();
        chk("ar_req_before", 32'(bus_req_o), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("ar_req", 32'(bus_req_o), 32'd0);
        chk("ar_addr", bus_addr_o, 32'd0);
        chk("ar_err", 32'(err_o), 32'd0);
        chk("ar_mrdata", mem_rdata_o, 32'd0);
        chk("ar_ifdata", if_data_o, 32'd0);
        chk("ar_stall", 32'(mem_stallreq_o), 32'd1);
        err_exp = 1'b0;
        #2 rst = 1'b1;
        slv_lat = 2;
        tick();
        chk("ar_rearb_req", 32'(bus_req_o), 32'd1);
        chk("ar_rearb_addr", bus_addr_o, 32'h20C);
        n = 1;
        while (mem_stallreq_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("ar_cycles", 32'(n), 32'd3);
        chk("ar_rdata", mem_rdata_o, ref_mem[131]);
        mem_ce_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
